// File: rtl/sinegen_pkg.sv
// sinegen_pkg
// Shared types and default widths for the sine-generator address sequencer.
//   state_e            : sequencer state (IDLE, RUN, STOPPING)
//   DEF_ADDRESS_WIDTH  : default ROM address width
//   DEF_ACC_WIDTH      : default phase accumulator width
//   DEF_CNT_WIDTH      : default burst wrap-counter width
package sinegen_pkg;

  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int DEF_ACC_WIDTH     = 16;
  localparam int DEF_CNT_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

endpackage

// File: rtl/sinegen_phase_acc.sv
// sinegen_phase_acc
// Phase accumulator register with its adder and carry-out.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   clear_i        : force the accumulator to zero on the next edge (wins over enable)
//   enable_i       : add incr_i to the accumulator on the next edge
//   incr_i         : phase increment (tuning word)
//   phase_o        : current accumulator MSBs (ROM address)
//   phase_next_o   : accumulator MSBs that will be loaded on the next edge
//   carry_o        : carry-out of acc + incr_i (raw, not gated by enable)
module sinegen_phase_acc
  import sinegen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int ACC_WIDTH     = DEF_ACC_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     enable_i,
  input  logic [ACC_WIDTH-1:0]     incr_i,
  output logic [ADDRESS_WIDTH-1:0] phase_o,
  output logic [ADDRESS_WIDTH-1:0] phase_next_o,
  output logic                     carry_o
);

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH-1:0] sum_s;

  // Adder with carry-out and next-state selection
  always_comb begin
    {carry_o, sum_s} = {1'b0, acc_q} + {1'b0, incr_i};
    if (clear_i) begin
      acc_d = '0;
    end else if (enable_i) begin
      acc_d = sum_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign phase_o      = acc_q[ACC_WIDTH-1 -: ADDRESS_WIDTH];
  assign phase_next_o = acc_d[ACC_WIDTH-1 -: ADDRESS_WIDTH];

endmodule

// File: rtl/sinegen_ctrl.sv
// sinegen_ctrl
// Phase-accumulator sequencer driving both address ports of a dual-port sine
// ROM with 1-cycle read latency. Channel 1 is the phase, channel 2 the phase
// plus a programmable offset. Tuning changes made while running take effect
// only at a phase wrap; stop requests complete at the next wrap.
// Optional feature macro: SINEGEN_CTRL_BURST_EN (adds burst_len, auto-stop
// after burst_len wraps; burst_len = 0 runs continuously).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   cfg_valid/cfg_ready   : config handshake for cfg_incr / cfg_offset
//   start, stop           : run control (stop wins when both are high in IDLE)
//   addr1, addr2          : ROM addresses (phase, phase + offset)
//   rom_valid             : ROM outputs valid this cycle
//   busy                  : high in RUN and STOPPING
//   wrap                  : one-cycle pulse when the accumulator carries out
module sinegen_ctrl
  import sinegen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ACC_WIDTH-1:0]     cfg_incr,
  input  logic [ADDRESS_WIDTH-1:0] cfg_offset,
  input  logic                     start,
  input  logic                     stop,
`ifdef SINEGEN_CTRL_BURST_EN
  input  logic [CNT_WIDTH-1:0]     burst_len,
`endif
  output logic [ADDRESS_WIDTH-1:0] addr1,
  output logic [ADDRESS_WIDTH-1:0] addr2,
  output logic                     rom_valid,
  output logic                     busy,
  output logic                     wrap
);

  state_e                   state_q, state_d;
  logic [ACC_WIDTH-1:0]     incr_q, incr_d;
  logic [ADDRESS_WIDTH-1:0] offset_q, offset_d;
  logic [ACC_WIDTH-1:0]     pend_incr_q, pend_incr_d;
  logic [ADDRESS_WIDTH-1:0] pend_offset_q, pend_offset_d;
  logic                     pending_q, pending_d;
  logic [ADDRESS_WIDTH-1:0] addr2_q;
  logic                     busy_q, rom_valid_q, wrap_q, cfg_ready_q;

  logic [ADDRESS_WIDTH-1:0] phase_s, phase_next_s;
  logic                     carry_s, clear_s, enable_s, wrap_evt_s;
  logic                     accept_s, burst_hit_s;

  sinegen_phase_acc #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .ACC_WIDTH     (ACC_WIDTH)
  ) u_phase_acc (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear_s),
    .enable_i     (enable_s),
    .incr_i       (incr_q),
    .phase_o      (phase_s),
    .phase_next_o (phase_next_s),
    .carry_o      (carry_s)
  );

  assign enable_s   = (state_q != IDLE);
  assign wrap_evt_s = enable_s && carry_s;
  assign accept_s   = cfg_valid && cfg_ready_q;

`ifdef SINEGEN_CTRL_BURST_EN
  logic [CNT_WIDTH-1:0] burst_q, burst_d;
  logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0] wcnt_inc_s;

  assign wcnt_inc_s  = wcnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  // The carry that brings the count to burst_len ends the burst.
  assign burst_hit_s = (state_q == RUN) && carry_s && (burst_q != '0) && (wcnt_inc_s == burst_q);

  // Burst length capture and wrap counting
  always_comb begin
    burst_d = burst_q;
    wcnt_d  = wcnt_q;
    if (state_q == IDLE) begin
      wcnt_d = '0;
      if (state_d == RUN) begin
        burst_d = burst_len;
      end else begin
        burst_d = burst_q;
      end
    end else if ((state_q == RUN) && carry_s) begin
      wcnt_d = wcnt_inc_s;
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // Burst registers
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_q <= '0;
      wcnt_q  <= '0;
    end else begin
      burst_q <= burst_d;
      wcnt_q  <= wcnt_d;
    end
  end
`else
  logic [CNT_WIDTH-1:0] unused_cnt_s;
  assign unused_cnt_s = '0;
  assign burst_hit_s  = 1'b0;
`endif

  // Next-state logic: sequencing, accumulator control and config transfer
  always_comb begin
    state_d       = state_q;
    clear_s       = 1'b0;
    incr_d        = incr_q;
    offset_d      = offset_q;
    pend_incr_d   = pend_incr_q;
    pend_offset_d = pend_offset_q;
    pending_d     = pending_q;

    case (state_q)
      IDLE: begin
        clear_s = 1'b1;
        if (start && !stop) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (burst_hit_s) begin
          state_d = IDLE;
          clear_s = 1'b1;
        end else if (stop) begin
          state_d = STOPPING;
        end else begin
          state_d = RUN;
        end
      end
      STOPPING: begin
        // A zero increment never wraps, so leave straight away.
        if (carry_s || (incr_q == '0)) begin
          state_d = IDLE;
          clear_s = 1'b1;
        end else begin
          state_d = STOPPING;
        end
      end
      default: begin
        state_d = IDLE;
        clear_s = 1'b1;
      end
    endcase

    // A pending config lands on the next wrap, or at once when going idle.
    // An accept in the carry cycle sees pending_q low and waits a full wrap.
    if (pending_q && ((state_d == IDLE) || wrap_evt_s)) begin
      incr_d    = pend_incr_q;
      offset_d  = pend_offset_q;
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    if (accept_s) begin
      if ((state_q == IDLE) || (state_d == IDLE)) begin
        incr_d   = cfg_incr;
        offset_d = cfg_offset;
      end else begin
        pend_incr_d   = cfg_incr;
        pend_offset_d = cfg_offset;
        pending_d     = 1'b1;
      end
    end else begin
      pend_incr_d = pend_incr_q;
    end
  end

  // State, config and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      incr_q        <= '0;
      offset_q      <= '0;
      pend_incr_q   <= '0;
      pend_offset_q <= '0;
      pending_q     <= 1'b0;
      addr2_q       <= '0;
      busy_q        <= 1'b0;
      rom_valid_q   <= 1'b0;
      wrap_q        <= 1'b0;
      cfg_ready_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      incr_q        <= incr_d;
      offset_q      <= offset_d;
      pend_incr_q   <= pend_incr_d;
      pend_offset_q <= pend_offset_d;
      pending_q     <= pending_d;
      addr2_q       <= phase_next_s + offset_d;
      busy_q        <= (state_d != IDLE);
      rom_valid_q   <= busy_q;
      wrap_q        <= wrap_evt_s;
      cfg_ready_q   <= !pending_d;
    end
  end

  assign addr1     = phase_s;
  assign addr2     = addr2_q;
  assign busy      = busy_q;
  assign rom_valid = rom_valid_q;
  assign wrap      = wrap_q;
  assign cfg_ready = cfg_ready_q;

endmodule
